// File: rtl/acc_batch_ctrl_if.sv
// Sample-in / result-out handshake bundle for the batch accumulator controller.
// The controller connects through the slave modport; producer and consumer drive through master.
interface acc_batch_ctrl_if #(
  parameter int DATA_W = 4,
  parameter int SUM_W  = 6
) ();
  logic              i_start;
  logic [DATA_W-1:0] i_data;
  logic              i_valid;
  logic              o_ready;
  logic [SUM_W-1:0]  o_sum;
  logic              o_overflow;
  logic              o_valid;
  logic              i_ready;
  logic              o_busy;

  modport master (
    output i_start, i_data, i_valid, i_ready,
    input  o_ready, o_sum, o_overflow, o_valid, o_busy
  );

  modport slave (
    input  i_start, i_data, i_valid, i_ready,
    output o_ready, o_sum, o_overflow, o_valid, o_busy
  );
endinterface

// File: rtl/acc_batch_ctrl.sv
// Batch controller: after a start request, sums BATCH_LEN samples into a wrapping
// accumulator with a sticky carry flag, then holds the result on a valid/ready port.
module acc_batch_ctrl #(
  parameter int DATA_W    = 4,
  parameter int SUM_W     = 6,
  parameter int BATCH_LEN = 8,
  parameter int CNT_W     = 4
) (
  input logic             clk,
  input logic             i_rst,
  acc_batch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BATCH_LEN - 1);

  state_t           state_r;
  state_t           state_s;
  logic [SUM_W-1:0] sum_r;
  logic             ovf_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ready_r;
  logic             valid_r;
  logic             busy_r;

  logic             start_s;
  logic             beat_s;
  logic             last_s;
  logic [SUM_W:0]   data_ext_s;
  logic [SUM_W:0]   add_s;

  // ready_r mirrors state_r==ST_ACCUM, so a beat never sees i_valid combinationally on o_ready
  assign start_s    = (state_r == ST_IDLE) & bus.i_start;
  assign beat_s     = ready_r & bus.i_valid;
  assign last_s     = beat_s & (cnt_r == LAST_CNT);
  assign data_ext_s = (SUM_W + 1)'(bus.i_data);
  assign add_s      = {1'b0, sum_r} + data_ext_s;

  // Next-state decode for the batch sequencer
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.i_start) begin
          state_s = ST_ACCUM;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (last_s) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_ACCUM;
        end
      end
      ST_DONE: begin
        if (valid_r & bus.i_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Accumulator, sticky carry and beat counter; cleared on start, advanced per beat
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      sum_r <= {SUM_W{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (start_s) begin
      sum_r <= {SUM_W{1'b0}};
      ovf_r <= 1'b0;
      cnt_r <= {CNT_W{1'b0}};
    end else if (beat_s) begin
      sum_r <= add_s[SUM_W-1:0];
      ovf_r <= ovf_r | add_s[SUM_W];
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      sum_r <= sum_r;
      ovf_r <= ovf_r;
      cnt_r <= cnt_r;
    end
  end

  // Handshake flags registered from the next state so they track state_r exactly
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      ready_r <= 1'b0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= (state_s == ST_ACCUM);
      valid_r <= (state_s == ST_DONE);
      busy_r  <= (state_s != ST_IDLE);
    end
  end

  assign bus.o_ready    = ready_r;
  assign bus.o_valid    = valid_r;
  assign bus.o_busy     = busy_r;
  assign bus.o_sum      = sum_r;
  assign bus.o_overflow = ovf_r;

endmodule
